// File: rtl/axi_b_arb_pkg.sv
// Shared definitions for the AXI B-channel round-robin arbiter.
// Holds the BRESP encodings and the output-stage state type.
package axi_b_arb_pkg;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } outState_t;

endpackage

// File: rtl/axi_b_rr_arb.sv
// Combinational round-robin pick: returns the first valid source at or
// after the pointer, searching upward and wrapping back to source 0.
module axi_b_rr_arb
   import axi_b_arb_pkg::*;
#(
   parameter int N_SLV     = 4,
   parameter int SEL_WIDTH = 2
) (
   input  logic [N_SLV-1:0]     i_valid,
   input  logic [SEL_WIDTH-1:0] i_ptr,
   output logic [SEL_WIDTH-1:0] o_grant,
   output logic                 o_anyValid
);

   logic                 w_hiFound;
   logic [SEL_WIDTH-1:0] w_hiIdx;
   logic                 w_loFound;
   logic [SEL_WIDTH-1:0] w_loIdx;

   // Two searches in one pass: the lowest valid at or above the pointer, and
   // the lowest valid overall; the second one covers the wrap-around case.
   always_comb begin
      w_hiFound = 1'b0;
      w_hiIdx   = '0;
      w_loFound = 1'b0;
      w_loIdx   = '0;
      for (int i = N_SLV - 1; i >= 0; i--) begin
         if (i_valid[i]) begin
            w_loFound = 1'b1;
            w_loIdx   = SEL_WIDTH'(i);
            if (i >= int'(i_ptr)) begin
               w_hiFound = 1'b1;
               w_hiIdx   = SEL_WIDTH'(i);
            end
         end
      end
   end

   assign o_grant    = w_hiFound ? w_hiIdx : w_loIdx;
   assign o_anyValid = w_loFound;

endmodule

// File: rtl/axi_b_arbiter.sv
// Round-robin merge of N_SLV AXI B channels into one registered B output.
// Optional feature macro: AXI_B_ARBITER_ERR_CNT_EN enables a saturating
// counter of SLVERR/DECERR beats handed downstream; otherwise err_cnt_o is 0.
module axi_b_arbiter
   import axi_b_arb_pkg::*;
#(
   parameter  int N_SLV         = 4,
   parameter  int ID_WIDTH      = 4,
   parameter  int USER_WIDTH    = 1,
   parameter  int ERR_CNT_WIDTH = 8,
   localparam int SEL_WIDTH     = (N_SLV > 1) ? $clog2(N_SLV) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [N_SLV-1:0]            slave_valid_i,
   input  logic [N_SLV*2-1:0]          slave_resp_i,
   input  logic [N_SLV*ID_WIDTH-1:0]   slave_id_i,
   input  logic [N_SLV*USER_WIDTH-1:0] slave_user_i,
   output logic [N_SLV-1:0]            slave_ready_o,
   output logic                        master_valid_o,
   output logic [1:0]                  master_resp_o,
   output logic [ID_WIDTH-1:0]         master_id_o,
   output logic [USER_WIDTH-1:0]       master_user_o,
   output logic [SEL_WIDTH-1:0]        master_sel_o,
   input  logic                        master_ready_i,
   output logic [ERR_CNT_WIDTH-1:0]    err_cnt_o
);

   outState_t             r_state;
   logic [SEL_WIDTH-1:0]  r_ptr;
   logic [SEL_WIDTH-1:0]  r_sel;
   logic [1:0]            r_resp;
   logic [ID_WIDTH-1:0]   r_id;
   logic [USER_WIDTH-1:0] r_user;

   logic                  w_ld;
   logic                  w_anyValid;
   logic                  w_load;
   logic [SEL_WIDTH-1:0]  w_grant;
   logic [SEL_WIDTH-1:0]  w_ptrNext;

   axi_b_rr_arb #(
      .N_SLV     (N_SLV),
      .SEL_WIDTH (SEL_WIDTH)
   ) u_rrArb (
      .i_valid    (slave_valid_i),
      .i_ptr      (r_ptr),
      .o_grant    (w_grant),
      .o_anyValid (w_anyValid)
   );

   // The register can take a new beat when empty or when its beat leaves now.
   assign w_ld   = (r_state == EMPTY) | master_ready_i;
   assign w_load = w_ld & w_anyValid;

   // Pointer moves one past the winner; explicit wrap handles non-power-of-2.
   assign w_ptrNext = (w_grant == SEL_WIDTH'(N_SLV - 1)) ? '0 : (w_grant + SEL_WIDTH'(1));

   // Ready goes only to the granted source; held low while reset is asserted
   // so no source sees a handshake for a beat that would be discarded.
   always_comb begin
      slave_ready_o = '0;
      if (w_load && !rst_i) begin
         slave_ready_o[w_grant] = 1'b1;
      end
   end

   // Output stage: load the granted beat, drain to EMPTY when nothing is
   // valid, and hold everything stable while the downstream stalls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= EMPTY;
         r_ptr   <= '0;
         r_sel   <= '0;
         r_resp  <= '0;
         r_id    <= '0;
         r_user  <= '0;
      end else if (w_ld) begin
         if (w_anyValid) begin
            r_state <= FULL;
            r_sel   <= w_grant;
            r_ptr   <= w_ptrNext;
            r_resp  <= slave_resp_i[int'(w_grant)*2 +: 2];
            r_id    <= slave_id_i[int'(w_grant)*ID_WIDTH +: ID_WIDTH];
            r_user  <= slave_user_i[int'(w_grant)*USER_WIDTH +: USER_WIDTH];
         end else begin
            r_state <= EMPTY;
         end
      end
   end

   assign master_valid_o = (r_state == FULL);
   assign master_resp_o  = r_resp;
   assign master_id_o    = r_id;
   assign master_user_o  = r_user;
   assign master_sel_o   = r_sel;

`ifdef AXI_B_ARBITER_ERR_CNT_EN
   logic [ERR_CNT_WIDTH-1:0] r_errCnt;
   logic                     w_errBeat;

   assign w_errBeat = master_valid_o & master_ready_i &
                      ((r_resp == SLVERR) | (r_resp == DECERR));

   // Count error responses as they leave; stick at all-ones instead of wrapping.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_errCnt <= '0;
      end else if (w_errBeat && (r_errCnt != '1)) begin
         r_errCnt <= r_errCnt + ERR_CNT_WIDTH'(1);
      end
   end

   assign err_cnt_o = r_errCnt;
`else
   assign err_cnt_o = '0;
`endif

endmodule
